// File: rtl/sha1_stream_ctrl.sv
`default_nettype none
// ============================================================================
// sha1_stream_ctrl : packs a 32-bit word stream into padded SHA-1 blocks,
//                    sequences the sha1_update core and returns the digest.
// Revision: 1.0
// ============================================================================
module sha1_stream_ctrl (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_last,
  input  logic [2:0]   in_bytes,
  output logic         core_start,
  output logic [511:0] core_data,
  output logic [159:0] core_hash_in,
  input  logic         core_done,
  input  logic [159:0] core_hash_out,
  output logic [159:0] digest,
  output logic         digest_valid,
  output logic         busy
);

  localparam logic [159:0] C_IV = 160'h67452301EFCDAB8998BADCFE10325476C3D2E1F0;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    HASH   = 2'd1,
    LENBLK = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [511:0]   blk_q, blk_d;
  logic [3:0]     wptr_q, wptr_d;
  logic [159:0]   h_q, h_d;
  logic [63:0]    len_q, len_d;
  logic           final_q, final_d;
  logic           need_len_q, need_len_d;
  logic           pend80_q, pend80_d;
  logic           start_q, start_d;
  logic           in_ready_q, in_ready_d;
  logic [159:0]   digest_q, digest_d;
  logic           digest_valid_q, digest_valid_d;
  logic           busy_q, busy_d;

  logic [2:0]     eff_bytes;
  logic [31:0]    byte_mask;
  logic [31:0]    pad80;
  logic [31:0]    pad_word;
  logic [6:0]     pos;
  logic [63:0]    len_new;
  logic           full_last;

  always_comb begin
    eff_bytes = (!in_last || (in_bytes > 3'd4)) ? 3'd4 : in_bytes;
    case (eff_bytes)
      3'd0:    begin byte_mask = 32'h0000_0000; pad80 = 32'h8000_0000; end
      3'd1:    begin byte_mask = 32'hFF00_0000; pad80 = 32'h0080_0000; end
      3'd2:    begin byte_mask = 32'hFFFF_0000; pad80 = 32'h0000_8000; end
      3'd3:    begin byte_mask = 32'hFFFF_FF00; pad80 = 32'h0000_0080; end
      default: begin byte_mask = 32'hFFFF_FFFF; pad80 = 32'h0000_0000; end
    endcase
    pad_word  = in_last ? pad80 : 32'h0;
    full_last = in_last && (eff_bytes == 3'd4);
    pos       = {1'b0, wptr_q, 2'b00} + {4'b0000, eff_bytes};
    len_new   = len_q + {58'd0, eff_bytes, 3'b000};
  end

  always_comb begin
    state_d        = state_q;
    blk_d          = blk_q;
    wptr_d         = wptr_q;
    h_d            = h_q;
    len_d          = len_q;
    final_d        = final_q;
    need_len_d     = need_len_q;
    pend80_d       = pend80_q;
    start_d        = 1'b0;
    in_ready_d     = in_ready_q;
    digest_d       = digest_q;
    digest_valid_d = 1'b0;
    busy_d         = busy_q;

    case (state_q)
      LOAD: begin
        if (in_valid) begin
          busy_d = 1'b1;
          len_d  = len_new;
          wptr_d = wptr_q + 4'd1;
          // The tail of the block after the last data word is rebuilt here so
          // the 0x80 marker and zero fill land in the same cycle as the data.
          for (int i = 0; i < 16; i++) begin
            if (4'(i) == wptr_q)
              blk_d[511-32*i -: 32] = (in_data & byte_mask) | pad_word;
            else if (in_last && (4'(i) > wptr_q))
              blk_d[511-32*i -: 32] = (full_last && (4'(i) == wptr_q + 4'd1)) ?
                                      32'h8000_0000 : 32'h0;
          end
          if (in_last) begin
            state_d    = HASH;
            start_d    = 1'b1;
            in_ready_d = 1'b0;
            if (full_last && (wptr_q == 4'd15)) begin
              pend80_d   = 1'b1;
              need_len_d = 1'b1;
            end else if (pos <= 7'd55) begin
              blk_d[63:0] = len_new;
              final_d     = 1'b1;
            end else begin
              need_len_d = 1'b1;
            end
          end else if (wptr_q == 4'd15) begin
            state_d    = HASH;
            start_d    = 1'b1;
            in_ready_d = 1'b0;
            final_d    = 1'b0;
          end
        end
      end

      HASH: begin
        // A done pulse coincident with our own start belongs to nothing we issued.
        if (core_done && !start_q) begin
          h_d = core_hash_out;
          if (final_q) begin
            state_d        = DONE;
            digest_d       = core_hash_out;
            digest_valid_d = 1'b1;
            busy_d         = 1'b0;
          end else if (need_len_q) begin
            state_d = LENBLK;
          end else begin
            state_d    = LOAD;
            blk_d      = '0;
            wptr_d     = 4'd0;
            in_ready_d = 1'b1;
          end
        end
      end

      LENBLK: begin
        blk_d      = {(pend80_q ? 8'h80 : 8'h00), 440'd0, len_q};
        need_len_d = 1'b0;
        pend80_d   = 1'b0;
        final_d    = 1'b1;
        state_d    = HASH;
        start_d    = 1'b1;
      end

      DONE: begin
        h_d        = C_IV;
        len_d      = '0;
        wptr_d     = 4'd0;
        blk_d      = '0;
        final_d    = 1'b0;
        need_len_d = 1'b0;
        pend80_d   = 1'b0;
        state_d    = LOAD;
        in_ready_d = 1'b1;
      end

      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= LOAD;
      blk_q          <= '0;
      wptr_q         <= 4'd0;
      h_q            <= C_IV;
      len_q          <= '0;
      final_q        <= 1'b0;
      need_len_q     <= 1'b0;
      pend80_q       <= 1'b0;
      start_q        <= 1'b0;
      in_ready_q     <= 1'b1;
      digest_q       <= '0;
      digest_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      blk_q          <= blk_d;
      wptr_q         <= wptr_d;
      h_q            <= h_d;
      len_q          <= len_d;
      final_q        <= final_d;
      need_len_q     <= need_len_d;
      pend80_q       <= pend80_d;
      start_q        <= start_d;
      in_ready_q     <= in_ready_d;
      digest_q       <= digest_d;
      digest_valid_q <= digest_valid_d;
      busy_q         <= busy_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign core_start   = start_q;
  assign core_data    = blk_q;
  assign core_hash_in = h_q;
  assign digest       = digest_q;
  assign digest_valid = digest_valid_q;
  assign busy         = busy_q;

endmodule
`default_nettype wire
